dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the riscv32b core: the slave end of the core's data port. It accepts the core's word address, per-byte write strobes and four write byte lanes, and returns 32-bit read data in the same cycle. It contains a byte-writable word RAM and a small memory-mapped peripheral block (GPIO register, free-running timer with compare interrupt, sticky status). It sits beside the core at SoC top level, opposite the instruction memory.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 4.
- MMIO_BASE, 32'h0001_0000: base of the peripheral region; must be 64 KiB aligned.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- data_addr  in  32  byte address from the core; bits [1:0] ignored for decode.
- datamem_wr  in  4  byte write strobes; bit i writes lane i; 4'b0000 means read.
- data_in0..data_in3  in  8 each  write byte lanes 0..3 (lane 0 = bits 7:0).
- data_out  out  32  read data to the core, combinational from address.
- gpio_out  out  32  GPIO register contents.
- timer_irq  out  1  timer compare interrupt, level, sticky.

## Operation
- Decode:
  - RAM region when data_addr[31:16]==16'h0000 and word index data_addr[15:2] < DEPTH_WORDS.
  - MMIO region when data_addr[31:16]==MMIO_BASE[31:16].
  - Any other address is a bad access.
- RAM:
  - Index is data_addr[log2(DEPTH_WORDS)+1:2].
  - Each set strobe writes its lane at the clock edge. Unset lanes are unchanged.
  - RAM contents are not reset.
- MMIO registers (offset = data_addr[15:0]; every writable register honours byte strobes):
  - 0x00 GPIO: read/write.
  - 0x04 TIMER: read/write. Increments by 1 every cycle and wraps 32'hFFFF_FFFF→0. A cycle with any strobe set to TIMER loads the merged bytes instead of incrementing; unstrobed bytes keep the current, unincremented value.
  - 0x08 CMP: read/write compare value.
  - 0x0C STATUS: bit0 = timer_irq, bit1 = bad_access, other bits read 0. Writing 1 to a bit clears it (W1C, lane 0 only).
  - Other MMIO offsets: reads return 0, writes are ignored, and they do not count as bad access.
- Interrupt:
  - When TIMER == CMP at a clock edge (value before update), status bit0 sets.
  - If set and W1C clear occur in the same cycle, set wins.
- Bad access:
  - Reads return 32'h0.
  - Writes are dropped.
  - bad_access (bit1) sets at the edge. Any access with address outside both regions counts, whether read or write.
  - If set and clear occur in the same cycle, set wins.
- Reads:
  - data_out is a combinational mux of RAM word / register / 0, selected by data_addr.
  - During a write cycle, data_out reflects pre-edge contents.

## Timing
- Write latency: new value is visible on data_out the cycle after the strobe edge.
- Read latency: 0 cycles, combinational from data_addr.
- timer_irq rises one cycle after the edge at which TIMER==CMP was sampled.
- Reset values (after the rst edge):
  - gpio_out=0
  - TIMER=0
  - CMP=32'hFFFF_FFFF
  - timer_irq=0
  - bad_access=0
- Reset behaviour:
  - rst has priority over every write and the counter increment.
  - A write in the reset cycle is lost.
  - RAM is untouched by reset.
- Timer continues counting while any RAM or other MMIO access occurs.
- Back-to-back writes to the same RAM word with different strobes merge correctly.
- No wait states and no stall output: the responder never back-pressures the core.

## Test plan
- RAM byte-write merge: write 32'h11223344 to 0x0000_0010 with strobe 4'b1111, then 8'hAA with strobe 4'b0100 → read returns 32'h11AA3344 on the next cycle.
- Same-cycle read during write: read 0x10 while writing 32'h55 to it → data_out shows the old value that cycle and 32'h00000055 the next cycle.
- Timer/compare:
  - After reset, write CMP=5 at cycle 0 → timer_irq rises the cycle after TIMER reads 5.
  - Write STATUS=1 → timer_irq clears.
  - Repeat with the clear coincident with the match → irq stays 1.
- Timer load and wrap:
  - Write TIMER=32'hFFFF_FFFE with strobe 4'b1111 → reads 32'hFFFF_FFFE the next cycle, then 32'hFFFF_FFFF, then 0.
  - Write with strobe 4'b0001 and lane 0 = 8'h00 → only byte 0 changes.
- Bad access:
  - Write to 0x0002_0000 → RAM and registers are unchanged, STATUS bit1=1, read data is 0.
  - Access at word index DEPTH_WORDS in the RAM region → same bad-access response.
  - Write STATUS=2 → bit1 clears.
- Mid-operation reset:
  - Set GPIO=32'hDEADBEEF, TIMER running, irq set.
  - Assert rst for one cycle together with a GPIO write → gpio_out=0, TIMER=0, CMP=32'hFFFF_FFFF, timer_irq=0, and RAM contents are preserved.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-writable word RAM plus a small MMIO block
// (GPIO, free-running timer with compare interrupt, sticky W1C status).
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [3:0]  datamem_wr,
  input  logic [7:0]  data_in0,
  input  logic [7:0]  data_in1,
  input  logic [7:0]  data_in2,
  input  logic [7:0]  data_in3,
  output logic [31:0] data_out,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);
  // The core has no valid/ready pair: every cycle is an access, a zero
  // strobe is a read, and the responder accepts everything with no stall.
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   wdata;
  logic          wr;
  logic          ram_hit;
  logic          mmio_hit;
  logic          bad_hit;
  logic [AW-1:0] ram_idx;
  logic [13:0]   reg_word;
  logic          sel_gpio;
  logic          sel_timer;
  logic          sel_cmp;
  logic          sel_status;
  logic          clr_irq;
  logic          clr_bad;
  logic          timer_match;
  logic          unused_addr_lsbs;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] gpio_q;
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        irq_q;
  logic        bad_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign wdata            = {data_in3, data_in2, data_in1, data_in0};
  assign wr               = |datamem_wr;
  assign unused_addr_lsbs = &{1'b0, data_addr[1:0]};

  assign ram_hit  = (data_addr[31:16] == 16'h0000) &&
                    ({18'b0, data_addr[15:2]} < DEPTH_WORDS);
  assign mmio_hit = (data_addr[31:16] == MMIO_BASE[31:16]);
  assign bad_hit  = !ram_hit && !mmio_hit;
  assign ram_idx  = data_addr[AW+1:2];
  assign reg_word = data_addr[15:2];

  assign sel_gpio   = mmio_hit && (reg_word == 14'd0);
  assign sel_timer  = mmio_hit && (reg_word == 14'd1);
  assign sel_cmp    = mmio_hit && (reg_word == 14'd2);
  assign sel_status = mmio_hit && (reg_word == 14'd3);

  // W1C lives in lane 0 only; the match compares pre-update values.
  assign clr_irq     = sel_status && datamem_wr[0] && data_in0[0];
  assign clr_bad     = sel_status && datamem_wr[0] && data_in0[1];
  assign timer_match = (timer_q == cmp_q);

  // RAM is never reset, but a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && ram_hit && datamem_wr[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q  <= 32'h0;
      timer_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      if (sel_gpio && wr) gpio_q <= merge_bytes(gpio_q, wdata, datamem_wr);
      if (sel_timer && wr) timer_q <= merge_bytes(timer_q, wdata, datamem_wr);
      else                 timer_q <= timer_q + 32'd1;
      if (sel_cmp && wr) cmp_q <= merge_bytes(cmp_q, wdata, datamem_wr);
      irq_q <= timer_match | (irq_q & ~clr_irq);
      bad_q <= bad_hit | (bad_q & ~clr_bad);
    end
  end

  always_comb begin
    data_out = 32'h0;
    if (ram_hit) begin
      data_out = mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_word)
        14'd0:   data_out = gpio_q;
        14'd1:   data_out = timer_q;
        14'd2:   data_out = cmp_q;
        14'd3:   data_out = {30'b0, bad_q, irq_q};
        default: data_out = 32'h0;
      endcase
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = irq_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan sequences plus
// a random phase, all read data checked through an expected-value queue.
module tb_dmem_responder;
  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] MMIO  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [3:0]  datamem_wr;
  logic [7:0]  data_in0, data_in1, data_in2, data_in3;
  logic [31:0] data_out;
  logic [31:0] gpio_out;
  logic        timer_irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_gpio, m_timer, m_cmp;
  logic        m_irq, m_bad;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .datamem_wr(datamem_wr),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out(data_out), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic is_ram(input logic [31:0] a);
    return (a[31:16] == 16'h0) && (int'(a[15:2]) < DEPTH);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (is_ram(a)) return m_mem[a[AW+1:2]];
    if (a[31:16] == MMIO[31:16]) begin
      case (int'(a[15:2]))
        0:       return m_gpio;
        1:       return m_timer;
        2:       return m_cmp;
        3:       return {30'b0, m_bad, m_irq};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic m_step(input logic r, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd);
    logic        mmio, match, c0, c1;
    logic [31:0] nt;
    if (r) begin
      m_gpio = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF; m_irq = 0; m_bad = 0;
      return;
    end
    mmio  = (a[31:16] == MMIO[31:16]);
    match = (m_timer == m_cmp);
    nt    = m_timer + 1;
    c0    = 0;
    c1    = 0;
    if (is_ram(a) && s != 0) m_mem[a[AW+1:2]] = merge(m_mem[a[AW+1:2]], wd, s);
    else if (mmio && s != 0) begin
      case (int'(a[15:2]))
        0: m_gpio = merge(m_gpio, wd, s);
        1: nt = merge(m_timer, wd, s);
        2: m_cmp = merge(m_cmp, wd, s);
        3: if (s[0]) begin c0 = wd[0]; c1 = wd[1]; end
        default: ;
      endcase
    end
    if (match) m_irq = 1; else if (c0) m_irq = 0;
    if (!is_ram(a) && !mmio) m_bad = 1; else if (c1) m_bad = 0;
    m_timer = nt;
  endtask

  // One bus cycle: drive at posedge+1, check at negedge, update model at posedge.
  task automatic cycle(input logic r, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input string tag);
    rst = r; data_addr = a; datamem_wr = s;
    {data_in3, data_in2, data_in1, data_in0} = wd;
    exp_q.push_back(m_read(a));
    @(negedge clk);
    chk({tag, "_dout"}, data_out, exp_q.pop_front());
    chk({tag, "_gpio"}, gpio_out, m_gpio);
    chk({tag, "_irq"}, {31'b0, timer_irq}, {31'b0, m_irq});
    @(posedge clk);
    m_step(r, a, s, wd);
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, MMIO, 4'b0000, 32'h0, tag);
  endtask

  initial begin
    rst = 1'b1; data_addr = MMIO; datamem_wr = 4'b0;
    {data_in3, data_in2, data_in1, data_in0} = 32'h0;
    repeat (2) @(posedge clk);
    m_step(1'b1, MMIO, 4'b0, 32'h0);
    #1;
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_irq", {31'b0, timer_irq}, 32'h0);
    chk("reset_gpio_read", data_out, 32'h0);

    // Compare match: CMP=5 written in cycle 0, irq rises after TIMER==5
    cycle(1'b0, MMIO + 8, 4'hF, 32'd5, "cmp5");
    for (int t = 1; t <= 5; t++) begin
      chk("irq_before_match", {31'b0, timer_irq}, 32'h0);
      cycle(1'b0, MMIO + 4, 4'h0, 32'h0, "tmr_run");
    end
    chk("irq_rise", {31'b0, timer_irq}, 32'h1);
    chk("tmr_after_match", data_out, 32'd6);
    cycle(1'b0, MMIO + 12, 4'b0001, 32'h1, "irq_clr");
    chk("irq_cleared", {31'b0, timer_irq}, 32'h0);

    // Clear coincident with match: set wins
    cycle(1'b0, MMIO + 4, 4'hF, 32'd100, "tmr_load100");
    cycle(1'b0, MMIO + 8, 4'hF, 32'd102, "cmp102");
    idle("idle");
    cycle(1'b0, MMIO + 12, 4'b0001, 32'h1, "clr_at_match");
    chk("irq_set_wins", {31'b0, timer_irq}, 32'h1);

    // Timer load and wrap, then single-byte load
    cycle(1'b0, MMIO + 4, 4'hF, 32'hFFFF_FFFE, "tmr_load");
    chk("tmr_fffe", data_out, 32'hFFFF_FFFE);
    cycle(1'b0, MMIO + 4, 4'h0, 32'h0, "tmr_rd");
    chk("tmr_ffff", data_out, 32'hFFFF_FFFF);
    cycle(1'b0, MMIO + 4, 4'h0, 32'h0, "tmr_rd");
    chk("tmr_wrap", data_out, 32'h0);
    cycle(1'b0, MMIO + 4, 4'hF, 32'h1234_56F0, "tmr_load2");
    chk("tmr_123456f0", data_out, 32'h1234_56F0);
    cycle(1'b0, MMIO + 4, 4'b0001, 32'h0, "tmr_byte0");
    chk("tmr_byte0_only", data_out, 32'h1234_5600);

    // RAM byte merge and read-during-write
    cycle(1'b0, 32'h10, 4'hF, 32'h1122_3344, "ram_full");
    chk("ram_full_rd", data_out, 32'h1122_3344);
    cycle(1'b0, 32'h10, 4'b0100, 32'h00AA_0000, "ram_lane2");
    chk("ram_merge", data_out, 32'h11AA_3344);
    cycle(1'b0, 32'h10, 4'hF, 32'h0000_0055, "ram_rdw");
    chk("ram_after_write", data_out, 32'h0000_0055);

    // Bad accesses
    cycle(1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, "ram_w0");
    cycle(1'b0, 32'h0002_0000, 4'hF, 32'h1234_5678, "bad_wr");
    chk("bad_rd_zero", data_out, 32'h0);
    cycle(1'b0, MMIO + 12, 4'h0, 32'h0, "status_rd");
    chk("bad_bit_set", {31'b0, data_out[1]}, 32'h1);
    cycle(1'b0, 32'h0, 4'h0, 32'h0, "ram_w0_rd");
    chk("bad_wr_dropped", data_out, 32'hCAFE_F00D);
    cycle(1'b0, MMIO + 12, 4'b0001, 32'h2, "bad_clr");
    chk("bad_bit_clr", {31'b0, data_out[1]}, 32'h0);
    cycle(1'b0, DEPTH * 4, 4'hF, 32'hFFFF_FFFF, "bad_depth");
    chk("bad_depth_zero", data_out, 32'h0);
    cycle(1'b0, MMIO + 12, 4'h0, 32'h0, "status_rd2");
    chk("bad_depth_set", {31'b0, data_out[1]}, 32'h1);
    cycle(1'b0, MMIO + 12, 4'b0001, 32'h2, "bad_clr2");

    // Mid-operation reset with a coincident GPIO write
    cycle(1'b0, MMIO, 4'hF, 32'hDEAD_BEEF, "gpio_set");
    chk("gpio_deadbeef", gpio_out, 32'hDEAD_BEEF);
    chk("irq_before_rst", {31'b0, timer_irq}, 32'h1);
    cycle(1'b1, MMIO, 4'hF, 32'h1234_5678, "rst_cycle");
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    rst = 1'b0; datamem_wr = 4'h0; data_addr = MMIO + 4;
    #1 chk("rst_timer", data_out, 32'h0);
    data_addr = MMIO + 8;
    #1 chk("rst_cmp", data_out, 32'hFFFF_FFFF);
    cycle(1'b0, 32'h10, 4'h0, 32'h0, "ram_keep");
    chk("ram_preserved", data_out, 32'h0000_0055);

    // Random traffic over initialised RAM words and all MMIO offsets
    for (int w = 0; w < 16; w++) cycle(1'b0, w * 4, 4'hF, $urandom, "rnd_init");
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      if ($urandom_range(0, 2) != 0) a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      else a = MMIO + 32'($urandom_range(0, 7) * 4);
      s = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cycle(1'b0, a, s, $urandom, "rnd");
    end

    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
